// File: rtl/fifo_pkg.sv
// Shared FIFO package: pointer-width helper and default geometry/thresholds
// used by both the single-clock and the dual-clock FIFOs.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  // Almost-full fires this many entries below Depth; almost-empty at this count.
  localparam int unsigned DEF_AF_MARGIN = 2;
  localparam int unsigned DEF_AE_THRESH = 2;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array storage for the FIFO.
// Ports:
//   clk_i      write clock
//   we_i       write enable
//   waddr_i    write index
//   wdata_i    write data
//   raddr_i    read index
//   rd_data_c  combinational (asynchronous) read data
// Contents are deliberately not reset.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned Width = DEF_WIDTH,
  parameter int unsigned Depth = DEF_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]        wdata_i,
  input  logic [clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]        rd_data_c
);

  logic [Width-1:0] mem_q [Depth];

  // Synchronous write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read port
  assign rd_data_c = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with almost-full/almost-empty thresholds,
// occupancy count and sticky overflow/underflow flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through reads;
// otherwise Data_out is loaded on the edge a read is accepted.
// Ports:
//   Clk, Rst_n                         clock, async active-low reset
//   Wr_en, Data_in                     write request / data
//   Wr_Full, Wr_Almost_Full            write-side status
//   Rd_en, Data_out                    read request (pop) / data
//   Rd_Empty, Rd_Almost_Empty          read-side status
//   Count                              occupancy 0..Depth
//   Overflow, Underflow, Clr_err       sticky errors and their clear
// All status outputs are registers loaded from next-state values, so there is
// no combinational path from Wr_en/Rd_en to any output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned Width     = DEF_WIDTH,
  parameter int unsigned Depth     = DEF_DEPTH,
  parameter int unsigned AF_Thresh = Depth - DEF_AF_MARGIN,
  parameter int unsigned AE_Thresh = DEF_AE_THRESH
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Wr_en,
  input  logic [Width-1:0]          Data_in,
  output logic                      Wr_Full,
  output logic                      Wr_Almost_Full,
  input  logic                      Rd_en,
  output logic [Width-1:0]          Data_out,
  output logic                      Rd_Empty,
  output logic                      Rd_Almost_Empty,
  output logic [clog2(Depth):0]     Count,
  output logic                      Overflow,
  output logic                      Underflow,
  input  logic                      Clr_err
);

  localparam int unsigned Addr_w = clog2(Depth);
  localparam int unsigned Ptr_w  = Addr_w + 1;

  typedef logic [Ptr_w-1:0] ptr_t;

  // Full when pointers differ only in the wrap bit
  localparam ptr_t FullXor = ptr_t'(1) << Addr_w;

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             count_q,  count_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;
  logic             afull_q,  afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q,    ovf_d;
  logic             udf_q,    udf_d;
  logic [Width-1:0] data_q,   data_d;

  logic              wr_acc;
  logic              rd_acc;
  logic [Addr_w-1:0] mem_raddr;
  logic [Width-1:0]  mem_rdata;

  assign wr_acc = Wr_en & ~full_q;
  assign rd_acc = Rd_en & ~empty_q;

  fifo_mem_2p #(
    .Width (Width),
    .Depth (Depth)
  ) u_mem (
    .clk_i     (Clk),
    .we_i      (wr_acc),
    .waddr_i   (wr_ptr_q[Addr_w-1:0]),
    .wdata_i   (Data_in),
    .raddr_i   (mem_raddr),
    .rd_data_c (mem_rdata)
  );

  // Pointer, count and flag next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ptr_t'(1);

    if (wr_acc && !rd_acc)      count_d = count_q + ptr_t'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - ptr_t'(1);

    full_d   = ((wr_ptr_d ^ rd_ptr_d) == FullXor);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    afull_d  = (count_d >= Ptr_w'(AF_Thresh));
    aempty_d = (count_d <= Ptr_w'(AE_Thresh));

    // Set has priority over clear
    if (Wr_en && full_q) ovf_d = 1'b1;
    else if (Clr_err)    ovf_d = 1'b0;

    if (Rd_en && empty_q) udf_d = 1'b1;
    else if (Clr_err)     udf_d = 1'b0;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Look ahead at the next head; bypass Data_in when the head is the word
  // being written this cycle. Hold while empty so Data_out stays 0 after reset.
  always_comb begin
    mem_raddr = rd_ptr_d[Addr_w-1:0];
    data_d    = data_q;
    if (!empty_d) begin
      if (wr_acc && (rd_ptr_d == wr_ptr_q)) data_d = Data_in;
      else                                  data_d = mem_rdata;
    end
  end
`else
  // Registered read: load the head word on the accepting edge
  always_comb begin
    mem_raddr = rd_ptr_q[Addr_w-1:0];
    data_d    = data_q;
    if (rd_acc) data_d = mem_rdata;
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      data_q   <= data_d;
    end
  end

  assign Wr_Full         = full_q;
  assign Wr_Almost_Full  = afull_q;
  assign Rd_Empty        = empty_q;
  assign Rd_Almost_Empty = aempty_q;
  assign Count           = count_q;
  assign Overflow        = ovf_q;
  assign Underflow       = udf_q;
  assign Data_out        = data_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at Width=8, Depth=16 (defaults).
// Works with or without SYNC_FIFO_FWFT_EN defined.
module tb_sync_fifo_param;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Wr_en;
  logic [7:0] Data_in;
  logic       Wr_Full;
  logic       Wr_Almost_Full;
  logic       Rd_en;
  logic [7:0] Data_out;
  logic       Rd_Empty;
  logic       Rd_Almost_Empty;
  logic [4:0] Count;
  logic       Overflow;
  logic       Underflow;
  logic       Clr_err;

  int n_vec = 0;
  int n_err = 0;

  sync_fifo_param dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .Wr_en           (Wr_en),
    .Data_in         (Data_in),
    .Wr_Full         (Wr_Full),
    .Wr_Almost_Full  (Wr_Almost_Full),
    .Rd_en           (Rd_en),
    .Data_out        (Data_out),
    .Rd_Empty        (Rd_Empty),
    .Rd_Almost_Empty (Rd_Almost_Empty),
    .Count           (Count),
    .Overflow        (Overflow),
    .Underflow       (Underflow),
    .Clr_err         (Clr_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Check the word a pop returns: registered mode shows it after the edge,
  // FWFT mode shows it before the edge.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, 32'(Data_out), 32'(exp));
    step();
`else
    step();
    chk(tag, 32'(Data_out), 32'(exp));
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},  32'(Count), 32'd0);
    chk({tag, "_empty"},  32'(Rd_Empty), 32'd1);
    chk({tag, "_full"},   32'(Wr_Full), 32'd0);
    chk({tag, "_aempty"}, 32'(Rd_Almost_Empty), 32'd1);
    chk({tag, "_afull"},  32'(Wr_Almost_Full), 32'd0);
    chk({tag, "_ovf"},    32'(Overflow), 32'd0);
    chk({tag, "_udf"},    32'(Underflow), 32'd0);
    chk({tag, "_dout"},   32'(Data_out), 32'd0);
  endtask

  initial begin
    Rst_n   = 1'b0;
    Wr_en   = 1'b0;
    Rd_en   = 1'b0;
    Clr_err = 1'b0;
    Data_in = 8'h00;

    // Reset
    repeat (2) step();
    chk_reset_state("rst");
    Rst_n = 1'b1;
    step();

    // Fill 0x01..0x10
    Wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      Data_in = 8'(i + 1);
      step();
      chk("fill_count", 32'(Count), 32'(i + 1));
      chk("fill_afull", 32'(Wr_Almost_Full), 32'(i + 1 >= 14));
      chk("fill_empty", 32'(Rd_Empty), 32'd0);
      chk("fill_full",  32'(Wr_Full), 32'(i + 1 == 16));
    end

    // Write while full: dropped, Overflow set
    Data_in = 8'hEE;
    step();
    Wr_en = 1'b0;
    chk("ovf_flag",  32'(Overflow), 32'd1);
    chk("ovf_count", 32'(Count), 32'd16);
    chk("ovf_full",  32'(Wr_Full), 32'd1);

    // Drain in order
    Rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pop_chk("drain_data", 8'(i + 1));
      chk("drain_count",  32'(Count), 32'(15 - i));
      chk("drain_aempty", 32'(Rd_Almost_Empty), 32'(15 - i <= 2));
      chk("drain_empty",  32'(Rd_Empty), 32'(i == 15));
    end

    // Read while empty: Underflow set, Data_out held in registered mode
    step();
    Rd_en = 1'b0;
    chk("udf_flag",  32'(Underflow), 32'd1);
    chk("udf_ovf",   32'(Overflow), 32'd1);
    chk("udf_count", 32'(Count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_dout",  32'(Data_out), 32'h10);
`endif

    // Clear, then set-wins-over-clear, then clear again
    Clr_err = 1'b1;
    step();
    chk("clr_ovf", 32'(Overflow), 32'd0);
    chk("clr_udf", 32'(Underflow), 32'd0);
    Rd_en = 1'b1;
    step();
    Rd_en = 1'b0;
    chk("setwins_udf", 32'(Underflow), 32'd1);
    step();
    Clr_err = 1'b0;
    chk("clr2_udf", 32'(Underflow), 32'd0);

    // Count 8 (0x20..0x27), then 20 cycles of simultaneous write+read
    Wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Data_in = 8'(8'h20 + i);
      step();
    end
    chk("sim_pre_count", 32'(Count), 32'd8);
    Rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Data_in = 8'(8'h28 + i);
      pop_chk("sim_data", 8'(8'h20 + i));
      chk("sim_count", 32'(Count), 32'd8);
    end
    Wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop_chk("sim_tail", 8'(8'h34 + i));
    end
    Rd_en = 1'b0;
    chk("sim_empty", 32'(Rd_Empty), 32'd1);

    // Full with both requests: read only, Overflow set
    Wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      Data_in = 8'(8'h40 + i);
      step();
    end
    chk("fb_full", 32'(Wr_Full), 32'd1);
    Data_in = 8'hCC;
    Rd_en = 1'b1;
    pop_chk("fb_data", 8'h40);
    Wr_en = 1'b0;
    chk("fb_count", 32'(Count), 32'd15);
    chk("fb_ovf",   32'(Overflow), 32'd1);
    chk("fb_nfull", 32'(Wr_Full), 32'd0);

    // Drain 10 to reach Count 5 (0x41..0x4A popped)
    for (int i = 0; i < 10; i++) begin
      pop_chk("pre_rst_data", 8'(8'h41 + i));
    end
    Rd_en = 1'b0;
    chk("pre_rst_count", 32'(Count), 32'd5);

    // Asynchronous reset between edges
    @(negedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    step();
    Rst_n = 1'b1;
    step();

`ifdef SYNC_FIFO_FWFT_EN
    // FWFT: word visible the cycle after the write without Rd_en
    Wr_en = 1'b1;
    Data_in = 8'hA5;
    step();
    Wr_en = 1'b0;
    chk("fwft_dout",  32'(Data_out), 32'hA5);
    chk("fwft_empty", 32'(Rd_Empty), 32'd0);
    Rd_en = 1'b1;
    step();
    Rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(Rd_Empty), 32'd1);
`else
    // Registered: data appears only after the read edge
    Wr_en = 1'b1;
    Data_in = 8'hA5;
    step();
    Wr_en = 1'b0;
    chk("std_nodata", 32'(Data_out), 32'h00);
    Rd_en = 1'b1;
    step();
    Rd_en = 1'b0;
    chk("std_dout",       32'(Data_out), 32'hA5);
    chk("std_pop_empty",  32'(Rd_Empty), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO with width and depth as parameters. It adds programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. It is intended for datapaths where producer and consumer share one clock, and it replaces dual-clock FIFO instances where no clock crossing is needed. The read-port mode (registered or first-word fall-through) is selected at compile time.

Parameters:
Width, 8, data word width in bits (>=1)
Depth, 16, number of entries; power of two, >=4
AF_Thresh, Depth-2, Wr_Almost_Full asserted when Count >= AF_Thresh
AE_Thresh, 2, Rd_Almost_Empty asserted when Count <= AE_Thresh
Addr_w (localparam), clog2(Depth), pointer index width

Ports:
Clk  input  1  single clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Wr_en  input  1  write request
Data_in  input  Width  write data
Wr_Full  output  1  FIFO full
Wr_Almost_Full  output  1  Count >= AF_Thresh
Rd_en  input  1  read request
Data_out  output  Width  read data
Rd_Empty  output  1  FIFO empty
Rd_Almost_Empty  output  1  Count <= AE_Thresh
Count  output  Addr_w+1  current occupancy, 0..Depth
Overflow  output  1  sticky: a write was attempted while full
Underflow  output  1  sticky: a read was attempted while empty
Clr_err  input  1  synchronous clear of Overflow/Underflow

Behaviour:
- Reset is asynchronous and active-low: Clk is the single clock, Rst_n asserts asynchronously and releases synchronously to Clk.
- Reset values: wr/rd pointers 0, Count 0, Rd_Empty 1, Wr_Full 0, Rd_Almost_Empty 1, Wr_Almost_Full 0, Overflow 0, Underflow 0, Data_out 0. Memory contents are not reset.
- Pointers are Addr_w+1 bits in binary. The MSB is a wrap bit. Full: the pointers differ only in the MSB. Empty: the pointers are equal.
- Write accepted = Wr_en & ~Wr_Full. On acceptance, mem[wr_ptr[Addr_w-1:0]] <= Data_in and wr_ptr increments, wrapping modulo 2*Depth.
- Read accepted = Rd_en & ~Rd_Empty. On acceptance, rd_ptr increments.
- Count update per edge: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- All flags are decoded from registered state only. There is no combinational path from Wr_en/Rd_en to any flag.
- Simultaneous write and read when neither full nor empty: both are accepted and Count is unchanged.
- Full with Wr_en & Rd_en: only the read is accepted, the write is dropped and Overflow is set. The next cycle has Count = Depth-1.
- Empty with Wr_en & Rd_en: only the write is accepted, the read is dropped and Underflow is set.
- Overflow is set on Wr_en & Wr_Full. Underflow is set on Rd_en & Rd_Empty.
- Clr_err clears both error flags. If a set condition and Clr_err occur in the same cycle, set wins.
- Standard read mode: Data_out <= mem[rd_ptr] on the edge where a read is accepted, i.e. 1-cycle read latency. Otherwise Data_out holds its value.
- Rst_n asserted mid-operation: all state returns to reset values immediately and stored data is discarded.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN
- Defined (first-word fall-through): whenever Rd_Empty=0, Data_out presents the oldest word with no Rd_en needed. Rd_en acts as a pop, and the next word appears in the same cycle the pointer advances. Data_out is don't-care when empty, but 0 after reset.
- Undefined: standard registered read mode as above.
- Flag and Count semantics are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - the clog2 constant function
  - default Width/Depth constants
  - threshold defaults, shared with the dual-clock FIFO
- One sub-module, fifo_mem_2p: a register-array memory with Width/Depth parameters, a synchronous write port and an asynchronous read port.
- The top level holds the pointers, Count, flags, error logic and read-mode logic.

Test Plan:
- Reset/fill: Rst_n low then high; write 16 words 0x01..0x10 with Depth=16 -> Wr_Full=1 and Count=16 after the 16th edge. Wr_Almost_Full rises when Count=14. Rd_Empty falls after the first write.
- Drain order: read 16 words -> Data_out returns 0x01..0x10 in order; Rd_Empty=1 after the last read; Rd_Almost_Empty=1 at Count<=2.
- Overflow/Underflow: write while full -> Overflow=1, Count stays 16, data unchanged. Read while empty -> Underflow=1. Pulse Clr_err -> both flags return to 0.
- Simultaneous access: at Count=8 assert Wr_en and Rd_en for 20 cycles -> Count stays 8 and pointers wrap past 2*Depth with correct data order. When full with both asserted -> Count=15 and Overflow=1.
- Async reset mid-stream: drop Rst_n between clock edges at Count=5 -> Count=0, Rd_Empty=1 and Data_out=0 without waiting for a clock edge.
- FWFT build: write 0xA5 to an empty FIFO -> Data_out=0xA5 the cycle after the write with no Rd_en. Pop -> Rd_Empty=1.
